// File: rtl/fifo_pkg.sv
// Shared width and pointer-wrap helpers for the single-clock FWFT FIFO.
package fifo_pkg;

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int ptr_w(input int depth);
      return ($clog2(depth) < 1) ? 1 : $clog2(depth);
   endfunction

   // Explicit wrap so non-power-of-2 depths never index past DEPTH-1.
   function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
      return (ptr >= depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_WIDTH storage: synchronous write, asynchronous read (distributed RAM).
module sync_fifo_mem #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16,
   parameter int PW         = 4
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [PW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [PW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with occupancy count and almost flags.
// Optional sticky overflow/underflow outputs under `define SYNC_FIFO_ERR_FLAGS_EN.
module sync_fifo_fwft
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16,
   parameter int AF_THRESH  = DEPTH - 2,
   parameter int AE_THRESH  = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     w_en,
   input  logic [DATA_WIDTH-1:0]    data_in,
   input  logic                     r_en,
   output logic [DATA_WIDTH-1:0]    data_out,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [cnt_w(DEPTH)-1:0]  count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
   ,
   output logic                     overflow,
   output logic                     underflow
`endif
);

   localparam int CW = cnt_w(DEPTH);
   localparam int PW = ptr_w(DEPTH);

   if (DEPTH < 2) begin : g_depth_chk
      $error("sync_fifo_fwft: DEPTH must be >= 2");
   end
   if (AF_THRESH > DEPTH) begin : g_af_chk
      $error("sync_fifo_fwft: AF_THRESH must not exceed DEPTH");
   end
   if (AE_THRESH >= AF_THRESH) begin : g_ae_chk
      $warning("sync_fifo_fwft: AE_THRESH >= AF_THRESH, almost flags overlap");
   end

   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count_next;
   logic          rd_acc;
   logic          wr_acc;

   // Handshake: w_en is a write request taken when !full (or a same-cycle pop
   // frees a slot); r_en pops the head when !empty. data_out is the head word
   // whenever empty=0, before r_en is raised. Refused requests change nothing.
   assign rd_acc = r_en & ~empty;
   assign wr_acc = w_en & (~full | rd_acc);

   always_comb begin
      count_next = count;
      if (wr_acc & ~rd_acc)      count_next = count + CW'(1);
      else if (rd_acc & ~wr_acc) count_next = count - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         count        <= '0;
         empty        <= 1'b1;
         full         <= 1'b0;
         almost_empty <= 1'b1;
         almost_full  <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= PW'(ptr_inc(32'(wr_ptr), DEPTH));
         if (rd_acc) rd_ptr <= PW'(ptr_inc(32'(rd_ptr), DEPTH));
         count        <= count_next;
         empty        <= (count_next == '0);
         full         <= (count_next == CW'(DEPTH));
         almost_empty <= (count_next <= CW'(AE_THRESH));
         almost_full  <= (count_next >= CW'(AF_THRESH));
      end
   end

   sync_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .PW         (PW)
   ) u_mem (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wr_ptr),
      .wdata (data_in),
      .raddr (rd_ptr),
      .rdata (data_out)
   );

`ifdef SYNC_FIFO_ERR_FLAGS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (w_en & ~wr_acc) overflow  <= 1'b1;
         if (r_en & empty)   underflow <= 1'b1;
      end
   end

   overflow_evt: assert property (@(posedge clk) disable iff (rst) !(w_en && !wr_acc))
      else $warning("sync_fifo_fwft: write dropped while full");
   underflow_evt: assert property (@(posedge clk) disable iff (rst) !(r_en && empty))
      else $warning("sync_fifo_fwft: read ignored while empty");
`endif

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Directed + randomized bench for sync_fifo_fwft (DEPTH=16 and DEPTH=5 instances)
// against a queue-based reference model.
module tb_sync_fifo_fwft;

   logic        clk = 1'b0;
   logic        rst;
   // DEPTH=16 instance
   logic        w_en16, r_en16;
   logic [31:0] din16, dout16;
   logic        full16, empty16, af16, ae16;
   logic [4:0]  cnt16;
   // DEPTH=5 instance
   logic        w_en5, r_en5;
   logic [31:0] din5, dout5;
   logic        full5, empty5, af5, ae5;
   logic [2:0]  cnt5;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
   logic        ovf16, udf16, ovf5, udf5;
   logic        m_ovf16, m_udf16, m_ovf5, m_udf5;
`endif

   logic [31:0] q16[$];
   logic [31:0] q5[$];
   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sync_fifo_fwft #(.DATA_WIDTH(32), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2)) u_dut16 (
      .clk(clk), .rst(rst), .w_en(w_en16), .data_in(din16), .r_en(r_en16),
      .data_out(dout16), .full(full16), .empty(empty16), .almost_full(af16),
      .almost_empty(ae16), .count(cnt16)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      , .overflow(ovf16), .underflow(udf16)
`endif
   );

   sync_fifo_fwft #(.DATA_WIDTH(32), .DEPTH(5), .AF_THRESH(3), .AE_THRESH(2)) u_dut5 (
      .clk(clk), .rst(rst), .w_en(w_en5), .data_in(din5), .r_en(r_en5),
      .data_out(dout5), .full(full5), .empty(empty5), .almost_full(af5),
      .almost_empty(ae5), .count(cnt5)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      , .overflow(ovf5), .underflow(udf5)
`endif
   );

   task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check16();
      int n;
      n = q16.size();
      chk_w("count16", 32'(cnt16), n);
      chk_b("empty16", empty16, n == 0);
      chk_b("full16", full16, n == 16);
      chk_b("almost_full16", af16, n >= 14);
      chk_b("almost_empty16", ae16, n <= 2);
      if (n > 0) chk_w("head16", dout16, q16[0]);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      chk_b("overflow16", ovf16, m_ovf16);
      chk_b("underflow16", udf16, m_udf16);
`endif
   endtask

   task automatic check5();
      int n;
      n = q5.size();
      chk_w("count5", 32'(cnt5), n);
      chk_b("count5_le_depth", cnt5 <= 3'd5, 1'b1);
      chk_b("empty5", empty5, n == 0);
      chk_b("full5", full5, n == 5);
      chk_b("almost_full5", af5, n >= 3);
      chk_b("almost_empty5", ae5, n <= 2);
      if (n > 0) chk_w("head5", dout5, q5[0]);
   endtask

   // One clock of the DEPTH=16 instance; the model applies the acceptance rules.
   task automatic step16(input logic w, input logic [31:0] d, input logic r);
      bit rd, wr;
      w_en16 = w; din16 = d; r_en16 = r;
      rd = r && (q16.size() > 0);
      wr = w && ((q16.size() < 16) || rd);
      if (rd) chk_w("fwft16", dout16, q16[0]);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      if (w && !wr) m_ovf16 = 1'b1;
      if (r && q16.size() == 0) m_udf16 = 1'b1;
`endif
      @(posedge clk); #1;
      if (rd) void'(q16.pop_front());
      if (wr) q16.push_back(d);
      w_en16 = 1'b0; r_en16 = 1'b0;
      check16();
   endtask

   task automatic step5(input logic w, input logic [31:0] d, input logic r);
      bit rd, wr;
      w_en5 = w; din5 = d; r_en5 = r;
      rd = r && (q5.size() > 0);
      wr = w && ((q5.size() < 5) || rd);
      if (rd) chk_w("fwft5", dout5, q5[0]);
      @(posedge clk); #1;
      if (rd) void'(q5.pop_front());
      if (wr) q5.push_back(d);
      w_en5 = 1'b0; r_en5 = 1'b0;
      check5();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      q16.delete();
      q5.delete();
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      m_ovf16 = 1'b0; m_udf16 = 1'b0; m_ovf5 = 1'b0; m_udf5 = 1'b0;
`endif
      check16();
      check5();
   endtask

   initial begin
      rst = 1'b1;
      w_en16 = 1'b0; r_en16 = 1'b0; din16 = '0;
      w_en5 = 1'b0; r_en5 = 1'b0; din5 = '0;
      @(posedge clk); #1;
      do_reset();
      chk_b("reset_empty16", empty16, 1'b1);
      chk_b("reset_ae16", ae16, 1'b1);

      // Fill 0x0..0xF, then a dropped 17th write of 0xAA.
      for (int i = 0; i < 16; i++) step16(1'b1, 32'(i), 1'b0);
      chk_w("fill_count", 32'(cnt16), 32'd16);
      step16(1'b1, 32'hAA, 1'b0);
      chk_w("drop_head", dout16, 32'h0);

      // Drain 16, then an extra read on empty.
      for (int i = 0; i < 16; i++) step16(1'b0, '0, 1'b1);
      step16(1'b0, '0, 1'b1);
      chk_w("drain_count", 32'(cnt16), 32'd0);

      // Simultaneous read/write while full.
      for (int i = 0; i < 16; i++) step16(1'b1, 32'(32'h100 + i), 1'b0);
      step16(1'b1, 32'h55, 1'b1);
      chk_b("rw_full_flag", full16, 1'b1);
      for (int i = 0; i < 16; i++) step16(1'b0, '0, 1'b1);

      // Simultaneous read/write while empty: only the write lands.
      step16(1'b1, 32'h77, 1'b1);
      chk_w("rw_empty_data", dout16, 32'h77);
      chk_w("rw_empty_count", 32'(cnt16), 32'd1);
      step16(1'b0, '0, 1'b1);

      // DEPTH=5 random interleaving across pointer wraps.
      for (int i = 0; i < 60; i++)
         step5($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 99) < 50);
      for (int i = 0; i < 6; i++) step5(1'b0, '0, 1'b1);

      // Random traffic on the deep instance too.
      for (int i = 0; i < 80; i++)
         step16($urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 45);
      for (int i = 0; i < 17; i++) step16(1'b0, '0, 1'b1);

      // Reset mid-stream with 7 entries.
      for (int i = 0; i < 7; i++) step16(1'b1, 32'(32'h200 + i), 1'b0);
      chk_w("pre_reset_count", 32'(cnt16), 32'd7);
      do_reset();
      step16(1'b1, 32'h300, 1'b0);
      chk_w("post_reset_first", dout16, 32'h300);
      step16(1'b0, '0, 1'b1);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      step16(1'b0, '0, 1'b1);
      chk_b("underflow_set", udf16, 1'b1);
      step16(1'b1, 32'h301, 1'b0);
      step16(1'b0, '0, 1'b1);
      chk_b("underflow_sticky", udf16, 1'b1);
      do_reset();
      chk_b("underflow_cleared", udf16, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
